// File: rtl/axi_sim_mem.sv
// axi_sim_mem: AXI4 slave memory model with independent read and write burst engines
module axi_sim_mem #(
  parameter int DATA_WD = 256,
  parameter int ID_WD = 14,
  parameter int ADDR_WD = 36,
  parameter int LEN_WD = 8,
  parameter int MEM_SIZE = 64,
  parameter logic [ADDR_WD-1:0] BASE_ADDR = 36'h0_8000_0000
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [ID_WD-1:0]     AWID,
  input  logic [ADDR_WD-1:0]   AWADDR,
  input  logic [LEN_WD-1:0]    AWLEN,
  input  logic [2:0]           AWSIZE,
  input  logic [3:0]           AWREGION,
  input  logic [1:0]           AWBURST,
  input  logic                 AWLOCK,
  input  logic [3:0]           AWCACHE,
  input  logic [2:0]           AWPROT,
  input  logic [3:0]           AWQOS,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [DATA_WD-1:0]   WDATA,
  input  logic [DATA_WD/8-1:0] WSTRB,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [ID_WD-1:0]     BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [ID_WD-1:0]     ARID,
  input  logic [ADDR_WD-1:0]   ARADDR,
  input  logic [LEN_WD-1:0]    ARLEN,
  input  logic [2:0]           ARSIZE,
  input  logic [3:0]           ARREGION,
  input  logic [1:0]           ARBURST,
  input  logic                 ARLOCK,
  input  logic [3:0]           ARCACHE,
  input  logic [2:0]           ARPROT,
  input  logic [3:0]           ARQOS,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [ID_WD-1:0]     RID,
  output logic [DATA_WD-1:0]   RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY
);
  localparam int B = DATA_WD / 8;
  localparam int BSH = $clog2(B);
  localparam longint MEM_BYTES = longint'(MEM_SIZE) << 20;
  localparam int DEPTH = int'(MEM_BYTES / B);
  localparam int IDX_WD = $clog2(DEPTH);
  localparam int AW1 = ADDR_WD + 1;
  localparam logic [AW1-1:0] LO = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0] HI = LO + AW1'(MEM_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_win(input logic [ADDR_WD-1:0] a);
    return AW1'(a) >= LO && AW1'(a) < HI;
  endfunction

  function automatic logic [IDX_WD-1:0] idx_of(input logic [ADDR_WD-1:0] a);
    return IDX_WD'((a - BASE_ADDR) >> BSH);
  endfunction

  logic [DATA_WD-1:0] mem [DEPTH];

  w_state_t w_state;
  logic [ADDR_WD-1:0] w_addr, w_step;
  logic [LEN_WD-1:0] w_len, w_cnt;
  logic w_err, w_fire, w_hit;
  logic [IDX_WD-1:0] w_idx;
  logic [DATA_WD-1:0] w_merge;

  assign w_fire = WREADY && WVALID;
  assign w_hit = in_win(w_addr);
  assign w_idx = idx_of(w_addr);

  always_comb begin
    w_merge = mem[w_idx];
    for (int i = 0; i < B; i++)
      if (WSTRB[i]) w_merge[8*i +: 8] = WDATA[8*i +: 8];
  end

  // Memory has no reset so content survives ARESETn
  always_ff @(posedge ACLK)
    if (w_fire && w_hit) mem[w_idx] <= w_merge;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY <= 1'b0;
      BVALID <= 1'b0;
      BID <= '0;
      BRESP <= '0;
      w_addr <= '0;
      w_step <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else
      case (w_state)
        W_IDLE: begin
          AWREADY <= 1'b1;
          if (AWREADY && AWVALID) begin
            w_state <= W_DATA;
            AWREADY <= 1'b0;
            WREADY <= 1'b1;
            BID <= AWID;
            w_addr <= AWADDR & ({ADDR_WD{1'b1}} << AWSIZE);
            w_step <= ADDR_WD'(1) << AWSIZE;
            w_len <= AWLEN;
            w_cnt <= '0;
            w_err <= 1'b0;
          end
        end
        W_DATA:
          if (w_fire) begin
            w_addr <= w_addr + w_step;
            w_cnt <= w_cnt + LEN_WD'(1);
            w_err <= w_err || !w_hit;
            if (w_cnt == w_len) begin
              w_state <= W_RESP;
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP <= (w_err || !w_hit) ? 2'b11 : 2'b00;
            end
          end
        default:
          if (BREADY) begin
            w_state <= W_IDLE;
            BVALID <= 1'b0;
            AWREADY <= 1'b1;
          end
      endcase

  r_state_t r_state;
  logic [ADDR_WD-1:0] r_addr, r_step, ar_base, f_addr;
  logic [LEN_WD-1:0] r_len, r_cnt;
  logic f_hit;
  logic [DATA_WD-1:0] f_data;

  // Fetch address is beat 0 of the incoming burst when idle, else the next beat
  assign ar_base = ARADDR & ({ADDR_WD{1'b1}} << ARSIZE);
  assign f_addr = r_state == R_IDLE ? ar_base : r_addr;
  assign f_hit = in_win(f_addr);
  assign f_data = f_hit ? mem[idx_of(f_addr)] : '0;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID <= 1'b0;
      RLAST <= 1'b0;
      RID <= '0;
      RDATA <= '0;
      RRESP <= '0;
      r_addr <= '0;
      r_step <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else if (r_state == R_IDLE) begin
      ARREADY <= 1'b1;
      if (ARREADY && ARVALID) begin
        r_state <= R_DATA;
        ARREADY <= 1'b0;
        RVALID <= 1'b1;
        RID <= ARID;
        RDATA <= f_data;
        RRESP <= f_hit ? 2'b00 : 2'b11;
        RLAST <= ARLEN == '0;
        r_addr <= ar_base + (ADDR_WD'(1) << ARSIZE);
        r_step <= ADDR_WD'(1) << ARSIZE;
        r_len <= ARLEN;
        r_cnt <= '0;
      end
    end else if (RREADY) begin
      if (RLAST) begin
        r_state <= R_IDLE;
        RVALID <= 1'b0;
        RLAST <= 1'b0;
        ARREADY <= 1'b1;
      end else begin
        RDATA <= f_data;
        RRESP <= f_hit ? 2'b00 : 2'b11;
        RLAST <= r_cnt + LEN_WD'(1) == r_len;
        r_cnt <= r_cnt + LEN_WD'(1);
        r_addr <= r_addr + r_step;
      end
    end

  logic unused_ok;
  assign unused_ok = ^{AWREGION, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, WLAST,
                       ARREGION, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS};
endmodule

// File: tb/tb_axi_sim_mem.sv
// tb_axi_sim_mem: self-checking bench for axi_sim_mem against a byte-addressed reference memory
module tb_axi_sim_mem;
  localparam longint BASE = 64'h8000_0000;
  localparam longint SIZE = 64'd64 << 20;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [13:0] AWID, ARID, BID, RID;
  logic [35:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [255:0] WDATA, RDATA;
  logic [31:0] WSTRB;
  logic [1:0] BRESP, RRESP;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [longint];
  logic [255:0] last_rdata;

  typedef struct {
    bit wr;
    logic [13:0] id;
    longint addr;
    int len;
    int size;
    int dmode;
    int smode;
    int rmode;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl [10];

  always #5 ACLK = ~ACLK;

  axi_sim_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWREGION(4'h0), .AWBURST(2'b10), .AWLOCK(1'b0), .AWCACHE(4'h0), .AWPROT(3'h0), .AWQOS(4'h0),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARREGION(4'h0), .ARBURST(2'b00), .ARLOCK(1'b0), .ARCACHE(4'h0), .ARPROT(3'h0), .ARQOS(4'h0),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_win(input longint a);
    return a >= BASE && a < BASE + SIZE;
  endfunction

  function automatic logic [255:0] mdl_word(input longint a);
    logic [255:0] w;
    longint wb;
    w = '0;
    wb = a & ~longint'(31);
    for (int k = 0; k < 32; k++)
      if (mdl.exists(wb + k)) w[8*k +: 8] = mdl[wb + k];
    return w;
  endfunction

  task automatic do_write(input logic [13:0] id, input longint addr, input int len, input int size,
                          input int dmode, input int smode, input int abort_at, output logic [1:0] resp);
    longint base, a, wb;
    logic [255:0] d;
    logic [31:0] s;
    bit err;
    int n;
    base = addr & ~((longint'(1) << size) - 1);
    err = 0;
    resp = 2'b00;
    AWID = id; AWADDR = addr[35:0]; AWLEN = len[7:0]; AWSIZE = size[2:0]; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 200) begin tick(); n++; end
    chk("awready_wait", n < 200, 1);
    tick();
    AWVALID = 1'b0;
    chk("wready_after_aw", WREADY, 1);
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        WVALID = 1'b0;
        return;
      end
      a = base + i * (longint'(1) << size);
      d = dmode == 0 ? {32{8'hA5}} : dmode == 1 ? {32{8'(i * 17)}} :
          {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      s = smode == 0 ? 32'hFFFF_FFFF : smode == 1 ? (i == 2 ? 32'h0000_000F : 32'hFFFF_FFFF) : $urandom();
      WDATA = d; WSTRB = s; WLAST = (i == len); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 200) begin tick(); n++; end
      chk("wready_wait", n < 200, 1);
      tick();
      if (in_win(a)) begin
        wb = a & ~longint'(31);
        for (int k = 0; k < 32; k++)
          if (s[k]) mdl[wb + k] = d[8*k +: 8];
      end else err = 1;
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    chk("bvalid_after_last_w", BVALID, 1);
    chk("bid", BID, id);
    chk("bresp", BRESP, err ? 2'b11 : 2'b00);
    resp = BRESP;
    if ($urandom_range(0, 1) == 1) begin
      tick();
      chk("bvalid_held", BVALID, 1);
      chk("bresp_held", BRESP, err ? 2'b11 : 2'b00);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_drop", BVALID, 0);
    chk("awready_after_b", AWREADY, 1);
  endtask

  task automatic do_read(input logic [13:0] id, input longint addr, input int len, input int size,
                         input int rmode, output logic [1:0] resp0);
    longint base, a;
    int n, beat, cyc;
    bit rr;
    base = addr & ~((longint'(1) << size) - 1);
    ARID = id; ARADDR = addr[35:0]; ARLEN = len[7:0]; ARSIZE = size[2:0]; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 200) begin tick(); n++; end
    chk("arready_wait", n < 200, 1);
    tick();
    ARVALID = 1'b0;
    chk("rvalid_after_ar", RVALID, 1);
    resp0 = RRESP;
    beat = 0;
    cyc = 0;
    while (beat <= len && cyc < 200) begin
      a = base + beat * (longint'(1) << size);
      rr = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      RREADY = rr;
      chk("rvalid", RVALID, 1);
      chk("rid", RID, id);
      chk("rdata", RDATA, in_win(a) ? mdl_word(a) : 256'h0);
      chk("rresp", RRESP, in_win(a) ? 2'b00 : 2'b11);
      chk("rlast", RLAST, beat == len);
      last_rdata = RDATA;
      tick();
      cyc++;
      if (rr) beat++;
    end
    RREADY = 1'b0;
    chk("r_burst_done", cyc < 200, 1);
    chk("rvalid_drop", RVALID, 0);
    chk("arready_after_last_r", ARREADY, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r, r2;
    longint ra;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;

    tbl[0] = '{1, 14'h0012, BASE + 64'h40, 0, 5, 0, 0, 0, 2'b00};
    tbl[1] = '{0, 14'h0021, BASE + 64'h40, 0, 5, 0, 0, 0, 2'b00};
    tbl[2] = '{1, 14'h0003, BASE + 64'h100, 3, 5, 1, 1, 0, 2'b00};
    tbl[3] = '{0, 14'h3FFF, BASE + 64'h100, 3, 5, 0, 0, 1, 2'b00};
    tbl[4] = '{1, 14'h0044, BASE - 64'h20, 1, 5, 1, 0, 0, 2'b11};
    tbl[5] = '{0, 14'h0045, BASE, 0, 5, 0, 0, 0, 2'b00};
    tbl[6] = '{0, 14'h0046, BASE + SIZE, 0, 5, 0, 0, 0, 2'b11};
    tbl[7] = '{1, 14'h0107, BASE + 64'h203, 3, 2, 2, 2, 0, 2'b00};
    tbl[8] = '{0, 14'h0108, BASE + 64'h200, 0, 5, 0, 0, 2, 2'b00};
    tbl[9] = '{0, 14'h0109, BASE + SIZE - 64'h20, 1, 5, 0, 0, 2, 2'b00};

    repeat (3) tick();
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_bid_bresp", {BID, BRESP}, 0);
    chk("rst_rid_rresp", {RID, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    #2;
    chk("awready_before_edge", AWREADY, 0);
    tick();
    chk("rel_awready", AWREADY, 1);
    chk("rel_arready", ARREADY, 1);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].dmode, tbl[i].smode, -1, r);
      else
        do_read(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].rmode, r);
      chk($sformatf("vec%0d_resp", i), r, tbl[i].exp);
    end

    do_read(14'h1, BASE + 64'h40, 0, 5, 0, r);
    chk("a5_word", last_rdata, {32{8'hA5}});
    do_read(14'h2, BASE + 64'h140, 0, 5, 0, r);
    chk("strb_beat2", last_rdata, 256'h2222_2222);
    do_read(14'h3, BASE + 64'h160, 0, 5, 0, r);
    chk("full_beat3", last_rdata, {32{8'h33}});
    do_read(14'h4, BASE, 0, 5, 0, r);
    chk("oor_burst_beat1", last_rdata, {32{8'h11}});

    do_write(14'h5, BASE + 64'h400, 3, 5, 2, 0, 2, r);
    ARESETn = 1'b0;
    #1;
    chk("midrst_wready", WREADY, 0);
    chk("midrst_awready", AWREADY, 0);
    chk("midrst_arready", ARREADY, 0);
    chk("midrst_bvalid", BVALID, 0);
    chk("midrst_rvalid", RVALID, 0);
    tick();
    ARESETn = 1'b1;
    tick();
    chk("midrst_rel_awready", AWREADY, 1);
    repeat (3) begin
      chk("midrst_no_bvalid", BVALID, 0);
      tick();
    end
    do_read(14'h6, BASE + 64'h400, 3, 5, 0, r);
    do_read(14'h7, BASE + 64'h440, 0, 5, 0, r);
    chk("midrst_unwritten", last_rdata, 256'h0);

    fork
      do_write(14'h8, BASE + 64'h2000, 7, 5, 2, 2, -1, r);
      do_read(14'h9, BASE + 64'h100, 3, 5, 2, r2);
    join
    chk("overlap_bresp", r, 2'b00);
    chk("overlap_rresp", r2, 2'b00);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: ra = BASE + SIZE - 64'h100 + longint'($urandom_range(0, 255));
        1: ra = BASE - 64'h80 + longint'($urandom_range(0, 127));
        default: ra = BASE + 64'h3000 + longint'($urandom_range(0, 2047));
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(14'($urandom()), ra, $urandom_range(0, 7), $urandom_range(0, 5), 2, 2, -1, r);
      else
        do_read(14'($urandom()), ra, $urandom_range(0, 7), $urandom_range(0, 5), 2, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
